// File: rtl/event_fragment_generator_if.sv
// Stream bundle for the event fragment generator: control/data inputs
// from the readout path, header/payload outputs toward the Ethernet transmitter.
interface event_fragment_generator_if;
  logic [31:0] s_ctrl_tdata;
  logic        s_ctrl_tvalid;
  logic        s_ctrl_tready;
  logic [63:0] s_data_tdata;
  logic        s_data_tlast;
  logic        s_data_tvalid;
  logic        s_data_tready;
  logic [47:0] m_fhdr_tdata;
  logic        m_fhdr_tvalid;
  logic        m_fhdr_tready;
  logic [63:0] m_frag_tdata;
  logic        m_frag_tlast;
  logic        m_frag_tvalid;
  logic        m_frag_tready;

  modport master (
    input  s_ctrl_tdata, s_ctrl_tvalid, output s_ctrl_tready,
    input  s_data_tdata, s_data_tlast, s_data_tvalid, output s_data_tready,
    output m_fhdr_tdata, m_fhdr_tvalid, input  m_fhdr_tready,
    output m_frag_tdata, m_frag_tlast, m_frag_tvalid, input  m_frag_tready
  );

  modport slave (
    output s_ctrl_tdata, s_ctrl_tvalid, input  s_ctrl_tready,
    output s_data_tdata, s_data_tlast, s_data_tvalid, input  s_data_tready,
    input  m_fhdr_tdata, m_fhdr_tvalid, output m_fhdr_tready,
    input  m_frag_tdata, m_frag_tlast, m_frag_tvalid, output m_frag_tready
  );
endinterface

// File: rtl/event_fragment_generator.sv
// Cuts each readout event into FRAG_QWORDS-sized fragments, each preceded by a
// 48-bit header in nack-word layout; repairs and counts length mismatches.
module event_fragment_generator #(
  parameter int    FRAG_QWORDS = 1024,
  parameter string DEBUG       = "TRUE"
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  event_fragment_generator_if.master    bus,
  output logic [7:0]                    err_count_o,
  output logic                          busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [16:0] FRAG_Q17   = 17'(FRAG_QWORDS);
  localparam logic [18:0] FRAG_BYTES = 19'(FRAG_QWORDS * 8);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [16:0] ceil_qwords(input logic [18:0] bytes);
    logic [19:0] sum;
    sum = {1'b0, bytes} + 20'd7;
    return sum[19:3];
  endfunction

  logic [1:0]  state;
  logic [11:0] addr_q;
  logic [16:0] remaining_q;
  logic [18:0] offset_q;
  logic        first_q;
  logic [10:0] beat_q;
  logic [7:0]  err_q;

  logic        frag_last;
  logic [10:0] frag_cnt;
  logic        final_beat;
  logic        data_fire;
  logic [18:0] ctrl_bytes;
  logic        ctrl_rsvd_unused;

  assign ctrl_bytes       = bus.s_ctrl_tdata[18:0];
  assign ctrl_rsvd_unused = bus.s_ctrl_tdata[19];

  // remaining <= FRAG_QWORDS <= 2047 whenever it is used as the count, so truncation is safe
  assign frag_last  = (remaining_q <= FRAG_Q17);
  assign frag_cnt   = frag_last ? remaining_q[10:0] : FRAG_Q17[10:0];
  assign final_beat = (beat_q == 11'd1);

  assign bus.s_ctrl_tready = (state == ST_IDLE);
  assign bus.m_fhdr_tvalid = (state == ST_HDR);
  assign bus.m_fhdr_tdata  = (state == ST_HDR) ?
                             {first_q, frag_last, 3'b000, frag_cnt, addr_q, 1'b0, offset_q} : '0;

  assign bus.m_frag_tvalid = (state == ST_DATA) && bus.s_data_tvalid;
  assign bus.m_frag_tdata  = bus.s_data_tdata;
  assign bus.m_frag_tlast  = (state == ST_DATA) && (final_beat || bus.s_data_tlast);
  assign bus.s_data_tready = (state == ST_DATA) ? bus.m_frag_tready : (state == ST_DRAIN);

  assign data_fire   = bus.s_data_tvalid && bus.s_data_tready;
  assign err_count_o = err_q;
  assign busy_o      = (state != ST_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      offset_q    <= '0;
      first_q     <= 1'b0;
      beat_q      <= '0;
      err_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.s_ctrl_tvalid) begin
            addr_q      <= bus.s_ctrl_tdata[31:20];
            remaining_q <= ceil_qwords(ctrl_bytes);
            offset_q    <= '0;
            first_q     <= 1'b1;
            if (ctrl_bytes == 19'd0) err_q <= sat_inc(err_q);
            else                     state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (bus.m_fhdr_tready) begin
            beat_q <= frag_cnt;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_fire) begin
            if (bus.s_data_tlast) begin
              // tlast anywhere but the final beat of the final fragment is early
              if (!(final_beat && frag_last)) err_q <= sat_inc(err_q);
              state <= ST_IDLE;
            end else if (final_beat) begin
              if (frag_last) begin
                err_q <= sat_inc(err_q);
                state <= ST_DRAIN;
              end else begin
                offset_q    <= offset_q + FRAG_BYTES;
                remaining_q <= remaining_q - FRAG_Q17;
                first_q     <= 1'b0;
                state       <= ST_HDR;
              end
            end else begin
              beat_q <= beat_q - 11'd1;
            end
          end
        end
        default: begin
          if (bus.s_data_tvalid && bus.s_data_tlast) state <= ST_IDLE;
        end
      endcase
    end
  end

  if (DEBUG == "TRUE") begin : g_ila
    // ILA attach point; debug probes carry no functional logic.
  end

endmodule
